// File: rtl/dbiu_mem_responder_pkg.sv
// Shared widths, FSM state type and wait limit for the dbiu memory responder.
`default_nettype none

package dbiu_mem_responder_pkg;

  localparam int DBUS_AW   = 32;
  localparam int DBUS_DW   = 32;
  localparam int DBUS_ISEL = DBUS_DW / 8;

  localparam int DBIU_RESP_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dbiu_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/dbiu_resp_lfsr.sv
// Seeded 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances one step when step=1.
`default_nettype none

module dbiu_resp_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (step) begin
      value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/dbiu_mem_responder.sv
// Memory-backed dbiu slave: word RAM with byte-select writes, acked after a programmable wait.
// Optional randomised wait per request when DBIU_RESP_RANDOM_WAIT_EN is defined.
`default_nettype none

module dbiu_mem_responder #(
  parameter int          DBUS_AW     = dbiu_mem_responder_pkg::DBUS_AW,
  parameter int          DBUS_DW     = dbiu_mem_responder_pkg::DBUS_DW,
  parameter int          DBUS_ISEL   = dbiu_mem_responder_pkg::DBUS_ISEL,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_m2dbiu,
  input  logic [DBUS_AW-1:0]   adr_m2dbiu,
  input  logic [DBUS_DW-1:0]   dat_m2dbiu,
  input  logic                 we_m2dbiu,
  input  logic [DBUS_ISEL-1:0] sel_m2dbiu,
  output logic [DBUS_DW-1:0]   dat_dbiu2m,
  output logic                 ack_dbiu2m,
  output logic                 oor_err
);

  import dbiu_mem_responder_pkg::*;

  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(DBIU_RESP_MAX_WAIT + 1);

  dbiu_resp_state_t      state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx_q;
  logic [DBUS_DW-1:0]    dat_q;
  logic                  we_q;
  logic [DBUS_ISEL-1:0]  sel_q;
  logic                  oor_q;

  logic [DBUS_DW-1:0]    mem [MEM_WORDS];

  logic [IW-1:0]         idx_in;
  logic                  oor_in;
  logic                  accept;
  logic [CW-1:0]         wait_sel;
  logic                  unused_adr_lsbs;

  assign idx_in          = adr_m2dbiu[IW+1:2];
  assign oor_in          = (adr_m2dbiu >> (IW + 2)) != '0;
  assign accept          = (state == IDLE) && req_m2dbiu;
  assign unused_adr_lsbs = ^adr_m2dbiu[1:0];

`ifdef DBIU_RESP_RANDOM_WAIT_EN
  localparam logic [CW:0] WAIT_MOD = (CW + 1)'(WAIT_CYCLES + 1);

  logic [15:0] lfsr;
  logic [CW:0] rnd_wait;
  logic        unused_lfsr_bits;

  dbiu_resp_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (accept),
    .value (lfsr)
  );

  // The LFSR value before this request's step selects its wait.
  assign rnd_wait         = {1'b0, lfsr[CW-1:0]} % WAIT_MOD;
  assign wait_sel         = rnd_wait[CW-1:0];
  assign unused_lfsr_bits = ^{lfsr[15:CW], rnd_wait[CW]};
`else
  assign wait_sel = CW'(WAIT_CYCLES);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ack_dbiu2m <= 1'b0;
      oor_err    <= 1'b0;
      idx_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      oor_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_dbiu2m <= 1'b0;
          if (accept) begin
            idx_q <= idx_in;
            dat_q <= dat_m2dbiu;
            we_q  <= we_m2dbiu;
            sel_q <= sel_m2dbiu;
            oor_q <= oor_in;
            if (wait_sel == '0) begin
              state      <= ACK;
              ack_dbiu2m <= 1'b1;
              oor_err    <= oor_err | oor_in;
            end else begin
              cnt   <= wait_sel;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state      <= ACK;
            ack_dbiu2m <= 1'b1;
            oor_err    <= oor_err | oor_q;
          end
        end
        ACK: begin
          state      <= IDLE;
          ack_dbiu2m <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          ack_dbiu2m <= 1'b0;
        end
      endcase
    end
  end

  // Write commits on the edge that closes the ACK cycle; reset forces IDLE so aborts never commit.
  always_ff @(posedge clk) begin
    if (state == ACK && we_q && !oor_q) begin
      for (int k = 0; k < DBUS_ISEL; k++) begin
        if (sel_q[k]) begin
          mem[idx_q][8*k +: 8] <= dat_q[8*k +: 8];
        end
      end
    end
  end

  assign dat_dbiu2m = (state == ACK && !we_q && !oor_q) ? mem[idx_q] : '0;

  a_req_held_in_wait : assert property (
    @(posedge clk) disable iff (reset) (state == WAIT) |-> req_m2dbiu
  ) else $error("dbiu_mem_responder: req dropped while waiting");

endmodule

`default_nettype wire

// File: tb/tb_dbiu_mem_responder.sv
// Randomised self-checking bench for dbiu_mem_responder against a word/byte-lane memory model.
`default_nettype none

module tb_dbiu_mem_responder;

  localparam int WA = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_v  [3];
  logic        we_v   [3];
  logic [31:0] adr_v  [3];
  logic [31:0] wdat_v [3];
  logic [3:0]  sel_v  [3];

  logic [31:0] rdat_a, rdat_b, rdat_c;
  logic        ack_a, ack_b, ack_c;
  logic        oor_a, oor_b, oor_c;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem_a_m [int];
  logic [31:0] mem_b_m [int];

  always #5 clk = ~clk;

  dbiu_mem_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .reset(reset), .req_m2dbiu(req_v[0]), .adr_m2dbiu(adr_v[0]),
    .dat_m2dbiu(wdat_v[0]), .we_m2dbiu(we_v[0]), .sel_m2dbiu(sel_v[0]),
    .dat_dbiu2m(rdat_a), .ack_dbiu2m(ack_a), .oor_err(oor_a)
  );

  dbiu_mem_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_m2dbiu(req_v[1]), .adr_m2dbiu(adr_v[1]),
    .dat_m2dbiu(wdat_v[1]), .we_m2dbiu(we_v[1]), .sel_m2dbiu(sel_v[1]),
    .dat_dbiu2m(rdat_b), .ack_dbiu2m(ack_b), .oor_err(oor_b)
  );

`ifdef DBIU_RESP_RANDOM_WAIT_EN
  dbiu_mem_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(7), .LFSR_SEED(16'hACE1)) dut_c (
    .clk(clk), .reset(reset), .req_m2dbiu(req_v[2]), .adr_m2dbiu(adr_v[2]),
    .dat_m2dbiu(wdat_v[2]), .we_m2dbiu(we_v[2]), .sel_m2dbiu(sel_v[2]),
    .dat_dbiu2m(rdat_c), .ack_dbiu2m(ack_c), .oor_err(oor_c)
  );
`else
  assign rdat_c = '0;
  assign ack_c  = 1'b0;
  assign oor_c  = 1'b0;
`endif

  function automatic logic ack_of(input int u);
    case (u)
      0:       return ack_a;
      1:       return ack_b;
      default: return ack_c;
    endcase
  endfunction

  function automatic logic [31:0] rdat_of(input int u);
    case (u)
      0:       return rdat_a;
      1:       return rdat_b;
      default: return rdat_c;
    endcase
  endfunction

  // Model: 1024 words; anything above byte address 0xFFF is out of range.
  function automatic logic [31:0] model_read(input int u, input logic [31:0] adr);
    int idx;
    if ((adr >> 12) != 0) return 32'h0;
    idx = int'(adr[11:2]);
    if (u == 0) return mem_a_m.exists(idx) ? mem_a_m[idx] : 32'h0;
    return mem_b_m.exists(idx) ? mem_b_m[idx] : 32'h0;
  endfunction

  task automatic model_write(input int u, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
    logic [31:0] w;
    int idx;
    if ((adr >> 12) != 0) return;
    idx = int'(adr[11:2]);
    w = model_read(u, adr);
    for (int k = 0; k < 4; k++) if (sel[k]) w[8*k +: 8] = dat[8*k +: 8];
    if (u == 0) mem_a_m[idx] = w; else mem_b_m[idx] = w;
  endtask

  // One transaction; lat counts cycles from the req cycle to the ack cycle (-1 on timeout).
  task automatic txn(input int u, input logic [31:0] adr, input logic [31:0] dat,
                     input logic we, input logic [3:0] sel,
                     output logic [31:0] rd, output int lat, output bit quiet);
    @(posedge clk); #1;
    req_v[u] = 1'b1; adr_v[u] = adr; wdat_v[u] = dat; we_v[u] = we; sel_v[u] = sel;
    lat = -1; rd = '0; quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_of(u) === 1'b1) begin
        lat = i;
        rd  = rdat_of(u);
        break;
      end
      if (rdat_of(u) !== 32'h0) quiet = 1'b0;
    end
    @(posedge clk); #1;
    req_v[u] = 1'b0;
    @(negedge clk);
    if (ack_of(u) !== 1'b0 || rdat_of(u) !== 32'h0) quiet = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ack_a !== 1'b0) $display("FAIL reset_ack got=%b exp=0", ack_a); else passed++;
    total++; if (rdat_a !== 32'h0) $display("FAIL reset_dat got=%h exp=0", rdat_a); else passed++;
    total++; if (oor_a !== 1'b0) $display("FAIL reset_oor got=%b exp=0", oor_a); else passed++;
    total++; if (ack_b !== 1'b0 || oor_b !== 1'b0) $display("FAIL reset_b ack=%b oor=%b exp=0,0", ack_b, oor_b); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; int lat; bit q;
    txn(0, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, rd, lat, q);
    model_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
    total++; if (lat != WA + 1) $display("FAIL wr_latency got=%0d exp=%0d", lat, WA + 1); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL wr_ack_data got=%h exp=0", rd); else passed++;
    txn(0, 32'h10, 32'h0, 1'b0, 4'hF, rd, lat, q);
    total++; if (lat != WA + 1) $display("FAIL rd_latency got=%0d exp=%0d", lat, WA + 1); else passed++;
    total++; if (rd !== model_read(0, 32'h10)) $display("FAIL rd_data got=%h exp=%h", rd, model_read(0, 32'h10)); else passed++;
    total++; if (!q) $display("FAIL rd_quiet got=nonzero-outside-ack exp=zero"); else passed++;
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; int lat; bit q;
    txn(0, 32'h20, 32'h11223344, 1'b1, 4'hF, rd, lat, q);
    model_write(0, 32'h20, 32'h11223344, 4'hF);
    txn(0, 32'h20, 32'hAABBCCDD, 1'b1, 4'b0101, rd, lat, q);
    model_write(0, 32'h20, 32'hAABBCCDD, 4'b0101);
    txn(0, 32'h20, 32'h0, 1'b0, 4'hF, rd, lat, q);
    total++; if (rd !== model_read(0, 32'h20)) $display("FAIL byte_sel got=%h exp=%h", rd, model_read(0, 32'h20)); else passed++;
    txn(0, 32'h20, 32'hFFFFFFFF, 1'b1, 4'h0, rd, lat, q);
    total++; if (lat != WA + 1) $display("FAIL sel0_latency got=%0d exp=%0d", lat, WA + 1); else passed++;
    txn(0, 32'h20, 32'h0, 1'b0, 4'hF, rd, lat, q);
    total++; if (rd !== model_read(0, 32'h20)) $display("FAIL sel0_noop got=%h exp=%h", rd, model_read(0, 32'h20)); else passed++;
  endtask

  task automatic test_random_rw();
    logic [31:0] rd, adr, dat, exp; int lat; bit q, we; logic [3:0] sel;
    for (int i = 0; i < 8; i++) begin
      dat = $urandom;
      txn(0, 32'h400 + 32'(4 * i), dat, 1'b1, 4'hF, rd, lat, q);
      model_write(0, 32'h400 + 32'(4 * i), dat, 4'hF);
    end
    for (int i = 0; i < 30; i++) begin
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom);
      dat = $urandom;
      adr = 32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      exp = we ? 32'h0 : model_read(0, adr);
      txn(0, adr, dat, we, sel, rd, lat, q);
      if (we) model_write(0, adr, dat, sel);
      total++; if (lat != WA + 1 || rd !== exp)
        $display("FAIL rand_op%0d we=%b adr=%h got lat=%0d dat=%h exp lat=%0d dat=%h", i, we, adr, lat, rd, WA + 1, exp);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, got [3]; int lat, n; int cyc [3]; bit q, extra;
    for (int i = 0; i < 3; i++) begin
      txn(1, 32'(4 * i), $urandom, 1'b1, 4'hF, rd, lat, q);
      model_write(1, 32'(4 * i), wdat_v[1], 4'hF);
    end
    total++; if (lat != 1) $display("FAIL w0_latency got=%0d exp=1", lat); else passed++;
    @(posedge clk); #1;
    req_v[1] = 1'b1; we_v[1] = 1'b0; sel_v[1] = 4'hF; adr_v[1] = 32'h0;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      if (ack_b === 1'b1) begin
        cyc[n] = i; got[n] = rdat_b; n++;
        @(posedge clk); #1;
        if (n < 3) adr_v[1] = 32'(4 * n); else req_v[1] = 1'b0;
      end
    end
    extra = 1'b0;
    repeat (3) begin @(negedge clk); if (ack_b !== 1'b0) extra = 1'b1; end
    total++; if (n != 3) $display("FAIL b2b_count got=%0d exp=3", n); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (n != 3 || cyc[k] != 2 * k + 1 || got[k] !== model_read(1, 32'(4 * k)))
        $display("FAIL b2b_ack%0d got cyc=%0d dat=%h exp cyc=%0d dat=%h", k, cyc[k], got[k], 2 * k + 1, model_read(1, 32'(4 * k)));
      else passed++;
    end
    total++; if (extra) $display("FAIL b2b_extra_ack got=1 exp=0"); else passed++;
  endtask

  task automatic test_oor();
    logic [31:0] rd; int lat; bit q;
    txn(0, 32'h0, 32'hCAFEF00D, 1'b1, 4'hF, rd, lat, q);
    model_write(0, 32'h0, 32'hCAFEF00D, 4'hF);
    total++; if (oor_a !== 1'b0) $display("FAIL oor_before got=%b exp=0", oor_a); else passed++;
    txn(0, 32'h1000, 32'h5, 1'b1, 4'hF, rd, lat, q);
    model_write(0, 32'h1000, 32'h5, 4'hF);
    total++; if (lat != WA + 1) $display("FAIL oor_wr_latency got=%0d exp=%0d", lat, WA + 1); else passed++;
    total++; if (oor_a !== 1'b1) $display("FAIL oor_set got=%b exp=1", oor_a); else passed++;
    txn(0, 32'h0, 32'h0, 1'b0, 4'hF, rd, lat, q);
    total++; if (rd !== model_read(0, 32'h0)) $display("FAIL oor_ram_untouched got=%h exp=%h", rd, model_read(0, 32'h0)); else passed++;
    txn(0, 32'h1000, 32'h0, 1'b0, 4'hF, rd, lat, q);
    total++; if (rd !== 32'h0 || lat != WA + 1) $display("FAIL oor_read got=%h lat=%0d exp=0 lat=%0d", rd, lat, WA + 1); else passed++;
    total++; if (oor_a !== 1'b1) $display("FAIL oor_sticky got=%b exp=1", oor_a); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; bit q, seen;
    txn(0, 32'h40, 32'h12345678, 1'b1, 4'hF, rd, lat, q);
    model_write(0, 32'h40, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    req_v[0] = 1'b1; we_v[0] = 1'b1; adr_v[0] = 32'h40; wdat_v[0] = 32'hFFFFFFFF; sel_v[0] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; req_v[0] = 1'b0;
    #1;
    total++; if (ack_a !== 1'b0 || rdat_a !== 32'h0) $display("FAIL rst_mid_outputs ack=%b dat=%h exp=0,0", ack_a, rdat_a); else passed++;
    total++; if (oor_a !== 1'b0) $display("FAIL rst_mid_oor got=%b exp=0", oor_a); else passed++;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); if (ack_a !== 1'b0) seen = 1'b1; end
    reset = 1'b0;
    repeat (4) begin @(negedge clk); if (ack_a !== 1'b0) seen = 1'b1; end
    total++; if (seen) $display("FAIL rst_mid_ack got=ack exp=none"); else passed++;
    txn(0, 32'h40, 32'h0, 1'b0, 4'hF, rd, lat, q);
    total++; if (rd !== model_read(0, 32'h40)) $display("FAIL rst_mid_uncommitted got=%h exp=%h", rd, model_read(0, 32'h40)); else passed++;
  endtask

`ifdef DBIU_RESP_RANDOM_WAIT_EN
  task automatic test_random_wait();
    int lat_run [2][100];
    logic [31:0] rd; int lat, expl, distinct; bit q, in_range, same; bit seen [16];
    logic [15:0] l;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      l = 16'hACE1;
      for (int i = 0; i < 100; i++) begin
        txn(2, 32'h1000, 32'h0, 1'b0, 4'hF, rd, lat, q);
        lat_run[r][i] = lat;
        expl = int'(l[3:0] % 4'd8) + 1;
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        total++; if (lat != expl) $display("FAIL rnd_lat r%0d i%0d got=%0d exp=%0d", r, i, lat, expl); else passed++;
      end
    end
    in_range = 1'b1; same = 1'b1; distinct = 0;
    for (int k = 0; k < 16; k++) seen[k] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (lat_run[0][i] < 1 || lat_run[0][i] > 8) in_range = 1'b0;
      else if (!seen[lat_run[0][i]]) begin seen[lat_run[0][i]] = 1'b1; distinct++; end
      if (lat_run[0][i] != lat_run[1][i]) same = 1'b0;
    end
    total++; if (!in_range) $display("FAIL rnd_range got=out-of-range exp=1..8"); else passed++;
    total++; if (distinct < 4) $display("FAIL rnd_distinct got=%0d exp>=4", distinct); else passed++;
    total++; if (!same) $display("FAIL rnd_repeat got=differs exp=identical"); else passed++;
  endtask
`endif

  initial begin
    for (int u = 0; u < 3; u++) begin
      req_v[u] = 1'b0; we_v[u] = 1'b0; adr_v[u] = '0; wdat_v[u] = '0; sel_v[u] = '0;
    end
    test_reset();
    test_write_read();
    test_byte_enables();
    test_random_rw();
    test_back_to_back();
    test_oor();
    test_reset_mid();
`ifdef DBIU_RESP_RANDOM_WAIT_EN
    test_random_wait();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/dbiu_mem_responder.md
Name: dbiu_mem_responder

Overview:
- Memory-backed responder for the per-CPU data-bus (dbiu) request interface: accepts req/adr/dat/we/sel from one CPU-side master and returns dat/ack after a programmable wait.
- Used as a standalone slave for unit-testing CPU bridges and the noif/if adapters without the coherent interconnect.
- One instance per CPU port; word-addressed internal RAM with byte-select writes.

Parameters:
DBUS_AW, 32, address width (from param_pkg)
DBUS_DW, 32, data width (from param_pkg)
DBUS_ISEL, 4, byte-select width, DBUS_DW/8 (from param_pkg)
MEM_WORDS, 1024, RAM depth in words, power of two
WAIT_CYCLES, 2, wait cycles between request accept and ack, 0..15
LFSR_SEED, 16'hACE1, LFSR reset value (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_m2dbiu  in  1  request valid from master
adr_m2dbiu  in  DBUS_AW  byte address
dat_m2dbiu  in  DBUS_DW  write data
we_m2dbiu  in  1  1 = write, 0 = read
sel_m2dbiu  in  DBUS_ISEL  byte enables
dat_dbiu2m  out  DBUS_DW  read data, valid only while ack is high
ack_dbiu2m  out  1  one-cycle completion pulse
oor_err  out  1  sticky out-of-range flag

Behaviour:
- Reset (async assert): ack_dbiu2m=0, dat_dbiu2m=0, oor_err=0, FSM=IDLE, wait counter=0. RAM is not reset; simulation init is all zeros.
- FSM states: IDLE, WAIT, ACK.
- IDLE: on req=1, latch adr/dat/we/sel. If WAIT_CYCLES=0, go to ACK; else load counter with WAIT_CYCLES and go to WAIT.
- WAIT: decrement the counter each cycle; at 1, go to ACK. The master holds req and fields stable; latched copies are used regardless.
- ACK: ack=1 for exactly one cycle; then return to IDLE.
- Latency: req first high in cycle N gives ack in cycle N+1+WAIT_CYCLES.
- Back-to-back: req still high in the IDLE cycle after ACK is a new request. Minimum spacing between acks is WAIT_CYCLES+2.
- Address decode:
  - word index = adr[log2(MEM_WORDS)+1:2]; adr[1:0] ignored.
  - Out-of-range means any bit of adr[DBUS_AW-1:log2(MEM_WORDS)+2] is set.
- Read: dat_dbiu2m = RAM[index] during the ACK cycle; 0 otherwise. Out-of-range reads return 0.
- Write:
  - Committed at the ACK-cycle clock edge, byte lane k updated iff sel[k].
  - sel=0 is a legal no-op that still acks.
  - Out-of-range writes are dropped.
  - dat_dbiu2m=0 on write acks.
- oor_err: set on the ACK of any out-of-range access; cleared only by reset.
- Reset mid-transaction: abort, no ack, pending write not committed.
- req dropped during WAIT (protocol violation): the transaction still completes with ack; an SVA assertion flags it in simulation.

Optional Feature:
- Macro: DBIU_RESP_RANDOM_WAIT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, reset to LFSR_SEED) advances one step per accepted request.
  - Wait for that request = lfsr[3:0] mod (WAIT_CYCLES+1), giving 0..WAIT_CYCLES.
  - A wait of 0 goes directly to ACK.
- Undefined: fixed WAIT_CYCLES latency; no LFSR logic is synthesized.

Decomposition:
- param_pkg gains:
  - typedef enum logic [1:0] dbiu_resp_state_t {IDLE, WAIT, ACK}
  - localparam DBIU_RESP_MAX_WAIT=15
- DBUS_* widths are already in param_pkg and are reused.
- One natural sub-module: dbiu_resp_lfsr (seeded 16-bit LFSR with step enable), instantiated only under DBIU_RESP_RANDOM_WAIT_EN.

Test Plan:
1. Write/read, WAIT_CYCLES=2: write adr=0x10, dat=0xDEADBEEF, sel=4'hF with req in cycle N -> ack in N+3. Then read adr=0x10 -> dat_dbiu2m=0xDEADBEEF in its ack cycle, 0 in the cycles around it.
2. Byte enables: preload 0x11223344 at adr=0x20, write dat=0xAABBCCDD with sel=4'b0101 -> read returns 0x11BB33DD.
3. Back-to-back, WAIT_CYCLES=0: req held high for 3 reads of 0x0/0x4/0x8 (master changes adr after each ack) -> acks in cycles N+1, N+3, N+5, each a single cycle, correct data each time.
4. Out-of-range, MEM_WORDS=1024: write adr=0x1000, dat=0x5 -> ack, oor_err=1 from that edge on. Read adr=0x0 -> 0 (RAM untouched). oor_err still 1.
5. Reset mid-operation: write issued, reset pulsed during WAIT -> no ack, ack=0/dat=0/oor_err=0 immediately; later read of that address returns the old value.
6. DBIU_RESP_RANDOM_WAIT_EN, WAIT_CYCLES=7, LFSR_SEED=16'hACE1: 100 reads -> every latency lies in 1..8 cycles, at least 4 distinct values occur, and the sequence repeats identically across two runs.
